// File: rtl/serial_input_register_if.sv
// CPU-side bundle for serial_input_register: rx pin, CPU strobes, received byte, flags and FSM state.
// SERIAL_INPUT_PARITY_EN adds the perr flag.
interface serial_input_register_if;
    logic       rx;
    logic       clr_fgi;
    logic       clr_err;
    logic [7:0] inpr;
    logic       fgi;
    logic       ovr;
    logic       ferr;
    logic       busy;
    logic [2:0] state;
`ifdef SERIAL_INPUT_PARITY_EN
    logic       perr;

    modport master (output rx, clr_fgi, clr_err,
                    input  inpr, fgi, ovr, ferr, busy, state, perr);
    modport slave  (input  rx, clr_fgi, clr_err,
                    output inpr, fgi, ovr, ferr, busy, state, perr);
`else
    modport master (output rx, clr_fgi, clr_err,
                    input  inpr, fgi, ovr, ferr, busy, state);
    modport slave  (input  rx, clr_fgi, clr_err,
                    output inpr, fgi, ovr, ferr, busy, state);
`endif
endinterface

// File: rtl/serial_input_register.sv
// Serial receiver (8N1, LSB first) feeding the CPU input register INPR with flag FGI.
// Define SERIAL_INPUT_PARITY_EN for 8E1 frames with a sticky perr flag.
module serial_input_register #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input logic                    clk,
    input logic                    rst,
    serial_input_register_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4,
        PARITY    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_n;
    logic             sync1, rxs;
    logic [CNT_W-1:0] timer;
    logic [2:0]       index;
    logic [7:0]       shift, inpr;
    logic             fgi, ovr, ferr;
    logic             timer_clr, start_ok, bit_en, stop_en;
    logic             frame_ok, frame_bad, accept, load, set_ovr;
`ifdef SERIAL_INPUT_PARITY_EN
    logic             par_en, par_bad, perr, set_perr;
`endif

    always_comb begin
        state_n   = state;
        timer_clr = 1'b0;
        start_ok  = 1'b0;
        bit_en    = 1'b0;
        stop_en   = 1'b0;
`ifdef SERIAL_INPUT_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n   = START;
                    timer_clr = 1'b1;
                end
            end
            START: begin
                // Mid-bit recheck rejects short glitches without touching any flag.
                if (timer == HALF_LAST) begin
                    timer_clr = 1'b1;
                    if (rxs) begin
                        state_n = IDLE;
                    end else begin
                        state_n  = DATA;
                        start_ok = 1'b1;
                    end
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_clr = 1'b1;
                    bit_en    = 1'b1;
                    if (index == 3'd7) begin
`ifdef SERIAL_INPUT_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_INPUT_PARITY_EN
            PARITY: begin
                if (timer == BIT_LAST) begin
                    timer_clr = 1'b1;
                    par_en    = 1'b1;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_clr = 1'b1;
                    stop_en   = 1'b1;
                    state_n   = rxs ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign frame_ok  = stop_en & rxs;
    assign frame_bad = stop_en & ~rxs;
`ifdef SERIAL_INPUT_PARITY_EN
    assign accept    = frame_ok & ~par_bad;
    assign set_perr  = frame_ok & par_bad;
`else
    assign accept    = frame_ok;
`endif
    // A clr_fgi in the completion cycle frees the register, so the new byte is taken.
    assign load      = accept & (~fgi | bus.clr_fgi);
    assign set_ovr   = accept & fgi & ~bus.clr_fgi;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            state <= IDLE;
            timer <= '0;
            index <= 3'd0;
            shift <= 8'h00;
            inpr  <= 8'h00;
            fgi   <= 1'b0;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            sync1 <= bus.rx;
            rxs   <= sync1;
            state <= state_n;
            if (timer_clr || state == IDLE || state == WAIT_HIGH) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (start_ok) begin
                index <= 3'd0;
            end else if (bit_en) begin
                shift[index] <= rxs;
                index        <= index + 3'd1;
            end
            if (load) begin
                inpr <= shift;
            end
            if (load) begin
                fgi <= 1'b1;
            end else if (bus.clr_fgi) begin
                fgi <= 1'b0;
            end
            if (set_ovr) begin
                ovr <= 1'b1;
            end else if (bus.clr_err) begin
                ovr <= 1'b0;
            end
            if (frame_bad) begin
                ferr <= 1'b1;
            end else if (bus.clr_err) begin
                ferr <= 1'b0;
            end
        end
    end

`ifdef SERIAL_INPUT_PARITY_EN
    // Even parity: data bits plus parity bit must hold an even number of ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad <= 1'b0;
            perr    <= 1'b0;
        end else begin
            if (par_en) begin
                par_bad <= ^{shift, rxs};
            end
            if (set_perr) begin
                perr <= 1'b1;
            end else if (bus.clr_err) begin
                perr <= 1'b0;
            end
        end
    end

    assign bus.perr = perr;
`endif

    assign bus.inpr  = inpr;
    assign bus.fgi   = fgi;
    assign bus.ovr   = ovr;
    assign bus.ferr  = ferr;
    assign bus.busy  = (state != IDLE);
    assign bus.state = state;
endmodule

// File: tb/tb_serial_input_register.sv
// Directed bench for serial_input_register: frames are driven on rx, expected flag/data
// snapshots are queued per frame and compared by a monitor whenever busy falls.
module tb_serial_input_register;
  localparam int CPB = 16;
`ifdef SERIAL_INPUT_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Edge (counted from the start-bit drive) at which fgi/inpr update.
  localparam int FGI_EDGE = 3 + CPB / 2 + NB * CPB;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  logic busy_prev = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  serial_input_register_if bus();
  serial_input_register #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  function automatic logic [W-1:0] pack(input logic [7:0] d, input logic f, input logic o,
                                        input logic e, input logic p);
    return {p, e, o, f, d};
  endfunction

  function automatic logic [W-1:0] status();
`ifdef SERIAL_INPUT_PARITY_EN
    return {bus.perr, bus.ferr, bus.ovr, bus.fgi, bus.inpr};
`else
    return {1'b0, bus.ferr, bus.ovr, bus.fgi, bus.inpr};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_flip, input int hold_low);
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      tick(CPB);
    end
`ifdef SERIAL_INPUT_PARITY_EN
    bus.rx = (^data) ^ par_flip;
    tick(CPB);
`endif
    bus.rx = stop_bit;
    tick(CPB);
    if (!stop_bit) begin
      tick(hold_low);
    end else begin
      bus.rx = 1'b1;
    end
  endtask

  task automatic pulse_clr_fgi();
    bus.clr_fgi = 1'b1;
    tick(1);
    bus.clr_fgi = 1'b0;
  endtask

  task automatic pulse_clr_err();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
  endtask

  // scoreboard monitor: one expected snapshot per frame end (busy falling, not by reset)
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (busy_prev && !bus.busy && !rst_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL frame_end: unexpected frame end, status %0h", status());
      end else begin
        e = exp_q.pop_front();
        check("frame_end", 32'(status()), 32'(e));
      end
    end
    busy_prev = bus.busy;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    bus.rx = 1'b1;
    bus.clr_fgi = 1'b0;
    bus.clr_err = 1'b0;
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_inpr", bus.inpr, 8'h00);
    check("rst_fgi", bus.fgi, 0);
    check("rst_ovr", bus.ovr, 0);
    check("rst_ferr", bus.ferr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", bus.state, 0);
    tick(1);
    rst = 1'b0;
    tick(4);

    // A5 with exact latency
    exp_q.push_back(pack(8'hA5, 1, 0, 0, 0));
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 0);
      begin
        repeat (FGI_EDGE - 1) @(posedge clk);
        @(negedge clk);
        check("fgi_before_latency", bus.fgi, 0);
        @(posedge clk);
        @(negedge clk);
        check("fgi_at_latency", bus.fgi, 1);
        check("inpr_at_latency", bus.inpr, 8'hA5);
        check("ovr_after_a5", bus.ovr, 0);
        check("ferr_after_a5", bus.ferr, 0);
        check("busy_after_a5", bus.busy, 0);
      end
    join
    tick(4);

    // short glitch
    exp_q.push_back(pack(8'hA5, 1, 0, 0, 0));
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(CPB);
    @(negedge clk);
    check("glitch_state", bus.state, 0);
    tick(1);

    // overrun
    pulse_clr_fgi();
    @(negedge clk);
    check("clr_fgi", bus.fgi, 0);
    tick(1);
    exp_q.push_back(pack(8'h3C, 1, 0, 0, 0));
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    tick(4);
    exp_q.push_back(pack(8'h3C, 1, 1, 0, 0));
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    tick(4);
    pulse_clr_err();
    @(negedge clk);
    check("clr_err_ovr", bus.ovr, 0);
    check("inpr_after_ovr", bus.inpr, 8'h3C);
    check("fgi_kept_by_clr_err", bus.fgi, 1);
    tick(1);

    // clr_fgi coinciding with frame completion
    pulse_clr_fgi();
    exp_q.push_back(pack(8'h11, 1, 0, 0, 0));
    send_frame(8'h11, 1'b1, 1'b0, 0);
    tick(4);
    exp_q.push_back(pack(8'h22, 1, 0, 0, 0));
    fork
      send_frame(8'h22, 1'b1, 1'b0, 0);
      begin
        repeat (FGI_EDGE - 1) @(posedge clk);
        #1 bus.clr_fgi = 1'b1;
        @(posedge clk);
        #1 bus.clr_fgi = 1'b0;
      end
    join
    tick(4);

    // framing error and break
    pulse_clr_fgi();
    exp_q.push_back(pack(8'h22, 0, 0, 1, 0));
    send_frame(8'h55, 1'b0, 1'b0, 40);
    @(negedge clk);
    check("break_state", bus.state, 4);
    check("break_busy", bus.busy, 1);
    check("break_ferr", bus.ferr, 1);
    check("break_fgi", bus.fgi, 0);
    tick(1);
    bus.rx = 1'b1;
    tick(CPB);
    exp_q.push_back(pack(8'h0F, 1, 0, 1, 0));
    send_frame(8'h0F, 1'b1, 1'b0, 0);
    tick(4);
    pulse_clr_err();
    @(negedge clk);
    check("clr_err_ferr", bus.ferr, 0);
    check("fgi_before_rst", bus.fgi, 1);
    tick(1);

    // reset during data bit 4
    fork
      send_frame(8'hFE, 1'b1, 1'b0, 0);
      begin
        repeat (85) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_inpr", bus.inpr, 8'h00);
        check("midrst_fgi", bus.fgi, 0);
        check("midrst_ovr", bus.ovr, 0);
        check("midrst_ferr", bus.ferr, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_state", bus.state, 0);
      end
    join
    tick(4);

`ifdef SERIAL_INPUT_PARITY_EN
    // 8'h01 needs parity 1; send 0
    exp_q.push_back(pack(8'h00, 0, 0, 0, 1));
    send_frame(8'h01, 1'b1, 1'b1, 0);
    tick(4);
    @(negedge clk);
    check("perr_set", bus.perr, 1);
    check("perr_fgi", bus.fgi, 0);
    tick(1);
    pulse_clr_err();
    @(negedge clk);
    check("perr_clr", bus.perr, 0);
    tick(1);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
